heap_arbiter: RTL and testbench

- Shares the single heap Memory action port between N_REQ instruction executors using a round-robin arbiter.
- Sequences each granted operation onto the heap: drives action and operands, generates the heapClock strobe, waits a fixed latency, then returns the result and a one-cycle done to the owner.
- Sits between the fpga program engines and the Memory instance; it is the only driver of heapClock/heapAction.

---
 rtl/heap_pkg.sv | 22 ++
 rtl/heap_arbiter_rr_pick.sv | 35 +++
 rtl/heap_arbiter.sv | 126 ++++++++++++
 tb/tb_heap_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// Shared definitions for the heap port arbiter.
// Action codes, FSM state encodings and width defaults.
package heap_pkg;

  localparam int ACTION_W_DEF = 8;
  localparam int DATA_W_DEF   = 12;

  localparam logic [ACTION_W_DEF-1:0] HEAP_NOP   = 8'd0;
  localparam logic [ACTION_W_DEF-1:0] HEAP_RESET = 8'd1;
  localparam logic [ACTION_W_DEF-1:0] HEAP_ALLOC = 8'd2;
  localparam logic [ACTION_W_DEF-1:0] HEAP_READ  = 8'd3;
  localparam logic [ACTION_W_DEF-1:0] HEAP_WRITE = 8'd4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_ISSUE    = 3'd1;
  localparam state_t S_STROBE   = 3'd2;
  localparam state_t S_WAIT     = 3'd3;
  localparam state_t S_COMPLETE = 3'd4;

endpackage

// File: rtl/heap_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// Ports: req vector, ptr start index -> one-hot gnt, idx, any.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int   j;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/heap_arbiter.sv
// Round-robin sharing of the heap Memory port between requesters.
// Ports: req/req_* in, gnt/done/rsp_data/busy out, heap* to Memory.
import heap_pkg::*;

module heap_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ACTION_W  = ACTION_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OP_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*ACTION_W-1:0] req_action,
  input  logic [N_REQ*DATA_W-1:0] req_array,
  input  logic [N_REQ*DATA_W-1:0] req_index,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  busy,
  output logic                  heapClock,
  output logic [ACTION_W-1:0]   heapAction,
  output logic [DATA_W-1:0]     heapArray,
  output logic [DATA_W-1:0]     heapIndex,
  output logic [DATA_W-1:0]     heapIn,
  input  logic [DATA_W-1:0]     heapOut
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(OP_CYCLES + 1);

  state_t           state;
  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] cnt;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             is_nop;

  rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req(req),
    .ptr(rr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  // The heap operand registers double as the latched request.
  assign is_nop = (heapAction == ACTION_W'(HEAP_NOP));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      rr         <= '0;
      owner      <= '0;
      cnt        <= '0;
      gnt        <= '0;
      done       <= '0;
      busy       <= 1'b0;
      rsp_data   <= '0;
      heapClock  <= 1'b0;
      heapAction <= '0;
      heapArray  <= '0;
      heapIndex  <= '0;
      heapIn     <= '0;
    end else begin
      done      <= '0;
      heapClock <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pick_any) begin
            state      <= S_ISSUE;
            owner      <= pick_idx;
            gnt        <= pick_gnt;
            busy       <= 1'b1;
            heapAction <= req_action[pick_idx*ACTION_W +: ACTION_W];
            heapArray  <= req_array[pick_idx*DATA_W +: DATA_W];
            heapIndex  <= req_index[pick_idx*DATA_W +: DATA_W];
            heapIn     <= req_data[pick_idx*DATA_W +: DATA_W];
          end
        end
        S_ISSUE: begin
          if (is_nop) begin
            state <= S_COMPLETE;
            done  <= gnt;
          end else begin
            state     <= S_STROBE;
            heapClock <= 1'b1;
          end
        end
        S_STROBE: begin
          cnt   <= CNT_W'(OP_CYCLES);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= S_COMPLETE;
            done  <= gnt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_COMPLETE: begin
          if (!is_nop) rsp_data <= heapOut;
          gnt        <= '0;
          busy       <= 1'b0;
          heapAction <= '0;
          heapArray  <= '0;
          heapIndex  <= '0;
          heapIn     <= '0;
          rr         <= (owner == IDX_W'(N_REQ - 1)) ?
                        '0 : owner + 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_heap_arbiter.sv
// Scoreboard bench for heap_arbiter with directed vectors.
// Stimulus pushes expected completions; a monitor pops on done.
module tb_heap_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_action;
  logic [47:0] req_array;
  logic [47:0] req_index;
  logic [47:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [11:0] rsp_data;
  logic        busy;
  logic        heapClock;
  logic [7:0]  heapAction;
  logic [11:0] heapArray;
  logic [11:0] heapIndex;
  logic [11:0] heapIn;
  logic [11:0] heapOut;

  heap_arbiter dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .req_action(req_action),
    .req_array(req_array),
    .req_index(req_index),
    .req_data(req_data),
    .gnt(gnt),
    .done(done),
    .rsp_data(rsp_data),
    .busy(busy),
    .heapClock(heapClock),
    .heapAction(heapAction),
    .heapArray(heapArray),
    .heapIndex(heapIndex),
    .heapIn(heapIn),
    .heapOut(heapOut)
  );

  typedef struct {
    int          idx;
    logic [11:0] data;
    int          at;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push(int idx, logic [11:0] d, int at);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    e.at   = at;
    q.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_op(int i, logic [7:0] a, logic [11:0] ar,
                        logic [11:0] ix, logic [11:0] d);
    req_action[i*8 +: 8]  = a;
    req_array[i*12 +: 12] = ar;
    req_index[i*12 +: 12] = ix;
    req_data[i*12 +: 12]  = d;
  endtask

  // Monitor: pops one expectation per done pulse, checks rsp next cycle.
  initial begin
    exp_t        e;
    logic        pend;
    logic [11:0] pend_data;
    pend = 1'b0;
    pend_data = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (pend) chk("rsp_data", 32'(rsp_data), 32'(pend_data));
        pend = 1'b0;
        chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
        if (done != 4'b0) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = q.pop_front();
            chk("done_owner", 32'(done), 32'(4'b1 << e.idx));
            chk("done_cycle", 32'(cyc), 32'(e.at));
            pend = 1'b1;
            pend_data = e.data;
          end
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  initial begin
    reset      = 1'b0;
    req        = '0;
    req_action = '0;
    req_array  = '0;
    req_index  = '0;
    req_data   = '0;
    heapOut    = '0;
    tick(2);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hclk", 32'(heapClock), 32'd0);
    chk("rst_hact", 32'(heapAction), 32'd0);
    chk("rst_rsp", 32'(rsp_data), 32'd0);
    reset = 1'b1;
    tick(1);

    // Single request on 2
    heapOut = 12'h123;
    set_op(2, 8'd1, 12'd7, 12'd3, 12'd5);
    req = 4'b0100;
    t0 = cyc;
    push(2, 12'h123, t0 + 5);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk("s_gnt", 32'(gnt), (k <= 5) ? 32'h4 : 32'h0);
      chk("s_hclk", 32'(heapClock), (k == 2) ? 32'd1 : 32'd0);
      chk("s_busy", 32'(busy), (k <= 5) ? 32'd1 : 32'd0);
      if (k == 1) begin
        req = 4'b0000;
        set_op(2, 8'd9, 12'd0, 12'd0, 12'd9);
      end
      if (k == 2) begin
        chk("s_hact", 32'(heapAction), 32'd1);
        chk("s_harr", 32'(heapArray), 32'd7);
        chk("s_hidx", 32'(heapIndex), 32'd3);
        chk("s_hin", 32'(heapIn), 32'd5);
      end
    end

    // Nop on 1
    heapOut = 12'hFFF;
    set_op(1, 8'd0, 12'd1, 12'd1, 12'd1);
    req = 4'b0010;
    t0 = cyc;
    push(1, 12'h123, t0 + 2);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk("n_hclk", 32'(heapClock), 32'd0);
      chk("n_gnt", 32'(gnt), (k <= 2) ? 32'h2 : 32'h0);
      if (k == 1) req = 4'b0000;
    end

    // Read return on 0, then nop on 3 keeps rsp_data
    heapOut = 12'h000;
    set_op(0, 8'd3, 12'd1, 12'd2, 12'd0);
    req = 4'b0001;
    t0 = cyc;
    push(0, 12'h5A5, t0 + 5);
    tick(1);
    req = 4'b0000;
    tick(2);
    heapOut = 12'h5A5;
    tick(3);
    chk("r_rsp", 32'(rsp_data), 32'h5A5);
    heapOut = 12'h777;
    set_op(3, 8'd0, 12'd0, 12'd0, 12'd0);
    req = 4'b1000;
    t0 = cyc;
    push(3, 12'h5A5, t0 + 2);
    tick(1);
    req = 4'b0000;
    tick(3);
    chk("r_hold", 32'(rsp_data), 32'h5A5);

    // All four held: order 0,1,2,3,0
    heapOut = 12'h0AB;
    for (int i = 0; i < 4; i++) set_op(i, 8'd2, 12'(i), 12'd0, 12'd0);
    req = 4'b1111;
    t0 = cyc;
    push(0, 12'h0AB, t0 + 5);
    push(1, 12'h0AB, t0 + 11);
    push(2, 12'h0AB, t0 + 17);
    push(3, 12'h0AB, t0 + 23);
    push(0, 12'h0AB, t0 + 29);
    tick(25);
    chk("a_gnt5", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick(5);

    // Withdrawn request still completes, no regrant
    set_op(0, 8'd1, 12'd0, 12'd0, 12'd0);
    req = 4'b0001;
    t0 = cyc;
    push(0, 12'h0AB, t0 + 5);
    tick(2);
    req = 4'b0000;
    for (int k = 3; k <= 10; k++) begin
      tick(1);
      chk("w_gnt", 32'(gnt), (k <= 5) ? 32'h1 : 32'h0);
    end

    // Reset mid-operation
    heapOut = 12'h111;
    set_op(1, 8'd1, 12'd4, 12'd4, 12'd4);
    req = 4'b0010;
    tick(1);
    req = 4'b0000;
    tick(2);
    reset = 1'b0;
    #1;
    chk("x_gnt", 32'(gnt), 32'd0);
    chk("x_done", 32'(done), 32'd0);
    chk("x_busy", 32'(busy), 32'd0);
    chk("x_hclk", 32'(heapClock), 32'd0);
    chk("x_hact", 32'(heapAction), 32'd0);
    chk("x_harr", 32'(heapArray), 32'd0);
    chk("x_hidx", 32'(heapIndex), 32'd0);
    chk("x_hin", 32'(heapIn), 32'd0);
    chk("x_rsp", 32'(rsp_data), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("x_idle", 32'(busy), 32'd0);

    heapOut = 12'h3C3;
    set_op(3, 8'd1, 12'd0, 12'd0, 12'd0);
    req = 4'b1000;
    t0 = cyc;
    push(3, 12'h3C3, t0 + 5);
    tick(1);
    chk("x_gnt3", 32'(gnt), 32'h8);
    req = 4'b0000;
    tick(5);

    // Pointer wrapped from 3 to 0: 0 beats 3
    heapOut = 12'h0AB;
    set_op(0, 8'd1, 12'd0, 12'd0, 12'd0);
    req = 4'b1001;
    t0 = cyc;
    push(0, 12'h0AB, t0 + 5);
    tick(1);
    chk("wrap_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick(5);

    tick(2);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
